// File: rtl/ycr_memif_pkg.sv
// Shared memory-interface encodings (command, access width, response code)
// plus the state type used by the request arbiter.
package ycr_memif_pkg;

   typedef enum logic {
      YCR_MEM_CMD_RD = 1'b0,
      YCR_MEM_CMD_WR = 1'b1
   } type_ycr_mem_cmd_e;

   typedef enum logic [1:0] {
      YCR_MEM_WIDTH_BYTE  = 2'b00,
      YCR_MEM_WIDTH_HWORD = 2'b01,
      YCR_MEM_WIDTH_WORD  = 2'b10
   } type_ycr_mem_width_e;

   typedef enum logic [1:0] {
      YCR_MEM_RESP_NOTRDY = 2'b00,
      YCR_MEM_RESP_RDY_OK = 2'b01,
      YCR_MEM_RESP_RDY_ER = 2'b10
   } type_ycr_mem_resp_e;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } type_arb_state_e;

endpackage

// File: rtl/ycr_tag_fifo.sv
// In-order FIFO of requester indices, one entry per request still awaiting
// its response. Pushes while full and pops while empty are ignored.
module ycr_tag_fifo #(
   parameter int DEPTH = 4,
   parameter int TW    = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [TW-1:0] push_tag,
   input  logic          pop,
   output logic [TW-1:0] head_tag,
   output logic          full,
   output logic          empty
);

   localparam int PW = $clog2(DEPTH);

   logic [TW-1:0] mem_q [DEPTH];
   logic [TW-1:0] mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          push_ok;
   logic          pop_ok;

   assign full     = (cnt_q == (PW+1)'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign head_tag = mem_q[rd_ptr_q];
   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_tag;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      if (push_ok && !pop_ok) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/ycr_mem_router_n.sv
// N-master to one-slave memory router: round-robin arbiter locked per request,
// with responses steered back to the issuer through an in-order tag FIFO.
module ycr_mem_router_n
   import ycr_memif_pkg::*;
#(
   parameter int NUM_PORTS   = 2,
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int OUTST_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_PORTS-1:0]   m_req,
   input  logic [NUM_PORTS-1:0]   m_cmd,
   input  logic [2*NUM_PORTS-1:0] m_width,
   input  logic [AW*NUM_PORTS-1:0] m_addr,
   input  logic [DW*NUM_PORTS-1:0] m_wdata,
   output logic [NUM_PORTS-1:0]   m_req_ack,
   output logic [DW*NUM_PORTS-1:0] m_rdata,
   output logic [2*NUM_PORTS-1:0] m_resp,
   output logic                   s_req,
   output logic                   s_cmd,
   output logic [1:0]             s_width,
   output logic [AW-1:0]          s_addr,
   output logic [DW-1:0]          s_wdata,
   input  logic                   s_req_ack,
   input  logic [DW-1:0]          s_rdata,
   input  logic [1:0]             s_resp,
   output logic                   resp_unexp
);

   localparam int TW = $clog2(NUM_PORTS);

   type_arb_state_e state_q, state_d;
   logic [TW-1:0]   grant_q, grant_d;
   logic [TW-1:0]   rr_q, rr_d;
   logic            resp_unexp_q, resp_unexp_d;

   logic [1:0]      width_a [NUM_PORTS];
   logic [AW-1:0]   addr_a  [NUM_PORTS];
   logic [DW-1:0]   wdata_a [NUM_PORTS];

   logic            sel_vld;
   logic [TW-1:0]   sel_idx;
   logic [TW-1:0]   cand;
   logic            gnt_vld;
   logic [TW-1:0]   gnt_idx;
   logic            accept;
   logic            resp_vld;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [TW-1:0]   head_tag;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign width_a[i]               = m_width[i*2 +: 2];
      assign addr_a[i]                = m_addr[i*AW +: AW];
      assign wdata_a[i]               = m_wdata[i*DW +: DW];
      assign m_resp[i*2 +: 2]         = (fifo_pop && head_tag == TW'(i)) ? s_resp : YCR_MEM_RESP_NOTRDY;
      assign m_rdata[i*DW +: DW]      = (fifo_pop && head_tag == TW'(i)) ? s_rdata : '0;
   end

   // Round-robin search starts just above the last accepted port and wraps.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      cand    = '0;
      for (int off = 1; off <= NUM_PORTS; off++) begin
         if (int'(rr_q) + off >= NUM_PORTS) begin
            cand = TW'(int'(rr_q) + off - NUM_PORTS);
         end else begin
            cand = TW'(int'(rr_q) + off);
         end
         if (!sel_vld && m_req[cand]) begin
            sel_vld = 1'b1;
            sel_idx = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      gnt_vld = 1'b0;
      gnt_idx = grant_q;
      case (state_q)
         ARB_IDLE: begin
            gnt_vld = sel_vld & ~fifo_full;
            gnt_idx = sel_idx;
         end
         ARB_LOCKED: begin
            gnt_vld = 1'b1;
         end
         default: ;
      endcase

      s_req  = gnt_vld & m_req[gnt_idx] & ~fifo_full & ~rst;
      accept = s_req & s_req_ack;

      // A grant accepted in the cycle it is issued never needs to lock.
      case (state_q)
         ARB_IDLE: begin
            if (gnt_vld) begin
               grant_d = gnt_idx;
               if (!accept) begin
                  state_d = ARB_LOCKED;
               end
            end
         end
         ARB_LOCKED: begin
            if (accept || !m_req[grant_q]) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
      if (accept) begin
         rr_d = gnt_idx;
      end
   end

   always_comb begin
      m_req_ack = '0;
      if (accept) begin
         m_req_ack[gnt_idx] = 1'b1;
      end
   end

   assign s_cmd   = gnt_vld ? m_cmd[gnt_idx]   : 1'b0;
   assign s_width = gnt_vld ? width_a[gnt_idx] : 2'b00;
   assign s_addr  = gnt_vld ? addr_a[gnt_idx]  : '0;
   assign s_wdata = gnt_vld ? wdata_a[gnt_idx] : '0;

   assign resp_vld     = (s_resp != YCR_MEM_RESP_NOTRDY) & ~rst;
   assign fifo_pop     = resp_vld & ~fifo_empty;
   assign resp_unexp_d = resp_unexp_q | (resp_vld & fifo_empty);
   assign resp_unexp   = resp_unexp_q;

   ycr_tag_fifo #(
      .DEPTH (OUTST_DEPTH),
      .TW    (TW)
   ) u_tag_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (accept),
      .push_tag (gnt_idx),
      .pop      (fifo_pop),
      .head_tag (head_tag),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         grant_q      <= '0;
         rr_q         <= TW'(NUM_PORTS - 1);
         resp_unexp_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         rr_q         <= rr_d;
         resp_unexp_q <= resp_unexp_d;
      end
   end

endmodule

// File: tb/tb_ycr_mem_router_n.sv
// Directed bench for the 4-port router: arbitration order, lock behaviour,
// response steering, FIFO-full back-pressure and unexpected-response flag.
module tb_ycr_mem_router_n;
   import ycr_memif_pkg::*;

   localparam int NP = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic              clk;
   logic              rst;
   logic [NP-1:0]     m_req;
   logic [NP-1:0]     m_cmd;
   logic [2*NP-1:0]   m_width;
   logic [AW*NP-1:0]  m_addr;
   logic [DW*NP-1:0]  m_wdata;
   logic [NP-1:0]     m_req_ack;
   logic [DW*NP-1:0]  m_rdata;
   logic [2*NP-1:0]   m_resp;
   logic              s_req;
   logic              s_cmd;
   logic [1:0]        s_width;
   logic [AW-1:0]     s_addr;
   logic [DW-1:0]     s_wdata;
   logic              s_req_ack;
   logic [DW-1:0]     s_rdata;
   logic [1:0]        s_resp;
   logic              resp_unexp;

   int n_tests = 0;
   int n_fail  = 0;
   logic [1:0] exp_q[$];
   logic [1:0] wid_tab [NP] = '{2'd0, 2'd1, 2'd2, 2'd0};
   logic       cmd_tab [NP] = '{1'b0, 1'b1, 1'b0, 1'b1};

   ycr_mem_router_n #(
      .NUM_PORTS   (NP),
      .AW          (AW),
      .DW          (DW),
      .OUTST_DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .m_req      (m_req),
      .m_cmd      (m_cmd),
      .m_width    (m_width),
      .m_addr     (m_addr),
      .m_wdata    (m_wdata),
      .m_req_ack  (m_req_ack),
      .m_rdata    (m_rdata),
      .m_resp     (m_resp),
      .s_req      (s_req),
      .s_cmd      (s_cmd),
      .s_width    (s_width),
      .s_addr     (s_addr),
      .s_wdata    (s_wdata),
      .s_req_ack  (s_req_ack),
      .s_rdata    (s_rdata),
      .s_resp     (s_resp),
      .resp_unexp (resp_unexp)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // driver tasks: inputs change 1 ns after the rising edge, checks run at the falling edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1; m_req = '0; s_req_ack = 1'b0; s_resp = YCR_MEM_RESP_NOTRDY;
      tick();
      rst = 1'b0;
   endtask

   task automatic check_grant(input int p, input string tag);
      check({tag, "_ack"},   128'(m_req_ack), 128'(4'b0001 << p));
      check({tag, "_sreq"},  128'(s_req),     128'(1'b1));
      check({tag, "_addr"},  128'(s_addr),    128'(32'h1000_0000 + 32'(p * 16)));
      check({tag, "_wdata"}, 128'(s_wdata),   128'(32'hA000_0000 + 32'(p)));
      check({tag, "_cmd"},   128'(s_cmd),     128'(cmd_tab[p]));
      check({tag, "_width"}, 128'(s_width),   128'(wid_tab[p]));
   endtask

   task automatic check_resp(input int p, input logic [1:0] code, input logic [31:0] data, input string tag);
      check({tag, "_resp"},  128'(m_resp),  128'(8'(code) << (2 * p)));
      check({tag, "_rdata"}, 128'(m_rdata), 128'(data) << (32 * p));
   endtask

   initial begin
      logic [31:0] rd;
      rst = 1'b1; m_req = '0; s_req_ack = 1'b0; s_resp = YCR_MEM_RESP_NOTRDY; s_rdata = '0;
      for (int i = 0; i < NP; i++) begin
         m_addr[i*AW +: AW]  = 32'h1000_0000 + 32'(i * 16);
         m_wdata[i*DW +: DW] = 32'hA000_0000 + 32'(i);
         m_cmd[i]            = cmd_tab[i];
         m_width[i*2 +: 2]   = wid_tab[i];
      end

      // reset state, with requests present while reset is held
      tick(); tick();
      m_req = 4'b0011; s_req_ack = 1'b1; s_resp = YCR_MEM_RESP_RDY_OK;
      settle();
      check("rst_sreq",  128'(s_req),      128'(0));
      check("rst_ack",   128'(m_req_ack),  128'(0));
      check("rst_resp",  128'(m_resp),     128'(0));
      check("rst_unexp", 128'(resp_unexp), 128'(0));

      // two masters alternate; responses one cycle behind go to the issuer
      for (int k = 0; k < 5; k++) begin
         tick();
         rst = 1'b0;
         m_req = (k < 4) ? 4'b0011 : 4'b0000;
         s_req_ack = 1'b1;
         s_resp = (k > 0) ? YCR_MEM_RESP_RDY_OK : YCR_MEM_RESP_NOTRDY;
         rd = 32'hD000_0000 + 32'(k);
         s_rdata = rd;
         settle();
         if (k < 4) begin
            check_grant(k % 2, "alt_grant");
            exp_q.push_back(2'(k % 2));
         end else begin
            check("alt_idle_sreq", 128'(s_req), 128'(0));
         end
         if (k > 0) check_resp(int'(exp_q.pop_front()), YCR_MEM_RESP_RDY_OK, rd, "alt_resp");
      end

      // four requesters after reset: grant order 0,1,2,3,0
      do_reset();
      for (int k = 0; k < 6; k++) begin
         tick();
         m_req = (k < 5) ? 4'b1111 : 4'b0000;
         s_req_ack = 1'b1;
         s_resp = (k > 0) ? YCR_MEM_RESP_RDY_OK : YCR_MEM_RESP_NOTRDY;
         rd = 32'hB000_0000 + 32'(k);
         s_rdata = rd;
         settle();
         if (k < 5) begin
            check_grant(k % 4, "rr4_grant");
            exp_q.push_back(2'(k % 4));
         end
         if (k > 0) check_resp(int'(exp_q.pop_front()), YCR_MEM_RESP_RDY_OK, rd, "rr4_resp");
      end

      // port 1 stays granted through 5 unacknowledged cycles
      tick();
      m_req = 4'b0011; s_req_ack = 1'b0; s_resp = YCR_MEM_RESP_NOTRDY;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) tick();
         settle();
         check("lock_ack",  128'(m_req_ack), 128'(0));
         check("lock_sreq", 128'(s_req),     128'(1));
         check("lock_addr", 128'(s_addr),    128'(32'h1000_0010));
      end
      tick();
      s_req_ack = 1'b1;
      settle();
      check_grant(1, "lock_acc1");
      tick();
      settle();
      check_grant(0, "lock_then0");
      tick();
      m_req = 4'b0000; s_resp = YCR_MEM_RESP_RDY_OK; s_rdata = 32'h0000_00C1;
      settle();
      check_resp(1, YCR_MEM_RESP_RDY_OK, 32'h0000_00C1, "lock_resp1");
      tick();
      s_resp = YCR_MEM_RESP_RDY_ER; s_rdata = 32'h0000_00C0;
      settle();
      check_resp(0, YCR_MEM_RESP_RDY_ER, 32'h0000_00C0, "lock_resp0");

      // master withdraws while locked: back to IDLE, nothing queued
      tick();
      s_resp = YCR_MEM_RESP_NOTRDY; m_req = 4'b0100; s_req_ack = 1'b0;
      settle();
      check("drop_lock_sreq", 128'(s_req),  128'(1));
      check("drop_lock_addr", 128'(s_addr), 128'(32'h1000_0020));
      tick();
      m_req = 4'b0000;
      settle();
      check("drop_sreq", 128'(s_req), 128'(0));
      tick();
      m_req = 4'b0001; s_req_ack = 1'b1;
      settle();
      check_grant(0, "drop_regrant");
      tick();
      m_req = 4'b0000; s_resp = YCR_MEM_RESP_RDY_OK; s_rdata = 32'h0000_00D0;
      settle();
      check_resp(0, YCR_MEM_RESP_RDY_OK, 32'h0000_00D0, "drop_nopush");

      // fill the tag FIFO, check back-pressure and resume after one pop
      for (int k = 0; k < 4; k++) begin
         tick();
         m_req = 4'b0001; s_req_ack = 1'b1; s_resp = YCR_MEM_RESP_NOTRDY;
         settle();
         check_grant(0, "full_fill");
      end
      tick();
      settle();
      check("full_sreq", 128'(s_req),     128'(0));
      check("full_ack",  128'(m_req_ack), 128'(0));
      tick();
      s_resp = YCR_MEM_RESP_RDY_OK; s_rdata = 32'h0000_00E0;
      settle();
      check("full_pop_sreq", 128'(s_req),     128'(0));
      check("full_pop_ack",  128'(m_req_ack), 128'(0));
      check_resp(0, YCR_MEM_RESP_RDY_OK, 32'h0000_00E0, "full_pop");
      tick();
      s_resp = YCR_MEM_RESP_NOTRDY;
      settle();
      check_grant(0, "full_resume");
      for (int j = 0; j < 4; j++) begin
         tick();
         m_req = 4'b0000; s_resp = YCR_MEM_RESP_RDY_OK;
         rd = 32'h0000_00E1 + 32'(j);
         s_rdata = rd;
         settle();
         check_resp(0, YCR_MEM_RESP_RDY_OK, rd, "full_drain");
      end
      tick();
      s_resp = YCR_MEM_RESP_NOTRDY;
      settle();
      check("full_no_unexp", 128'(resp_unexp), 128'(0));

      // response with nothing outstanding is dropped and flagged until reset
      tick();
      s_resp = YCR_MEM_RESP_RDY_ER; s_rdata = 32'h0000_00F0;
      settle();
      check("unexp_drop_resp",  128'(m_resp),  128'(0));
      check("unexp_drop_rdata", 128'(m_rdata), 128'(0));
      tick();
      s_resp = YCR_MEM_RESP_NOTRDY;
      settle();
      check("unexp_set", 128'(resp_unexp), 128'(1));
      tick(); tick(); tick();
      settle();
      check("unexp_sticky", 128'(resp_unexp), 128'(1));
      do_reset();
      settle();
      check("unexp_cleared", 128'(resp_unexp), 128'(0));

      // reset with three outstanding tags discards them
      for (int k = 0; k < 3; k++) begin
         tick();
         m_req = 4'b0111; s_req_ack = 1'b1;
         settle();
         check_grant(k, "rst3_fill");
      end
      tick();
      rst = 1'b1; m_req = 4'b0000; s_resp = YCR_MEM_RESP_RDY_OK; s_rdata = 32'h0000_0AA0;
      settle();
      check("rst3_in_rst_resp", 128'(m_resp),    128'(0));
      check("rst3_in_rst_ack",  128'(m_req_ack), 128'(0));
      check("rst3_in_rst_sreq", 128'(s_req),     128'(0));
      tick();
      rst = 1'b0;
      settle();
      check("rst3_after_resp", 128'(m_resp), 128'(0));
      tick();
      s_resp = YCR_MEM_RESP_NOTRDY;
      settle();
      check("rst3_unexp", 128'(resp_unexp), 128'(1));

      // final report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ycr_mem_router_n.md
YCR_MEM_ROUTER_N -- requirements
Module: ycr_mem_router_n

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requesting masters (range 2..8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have parameter OUTST_DEPTH, default 4, maximum accepted-but-unanswered requests (power of two, 2..16).
REQ-005 SHALL have ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- m_req  in  NUM_PORTS  per-master request.
- m_cmd  in  NUM_PORTS  per-master command (read/write).
- m_width  in  2*NUM_PORTS  per-master access width.
- m_addr  in  AW*NUM_PORTS  per-master address; port i at bits [i*AW +: AW].
- m_wdata  in  DW*NUM_PORTS  per-master write data.
- m_req_ack  out  NUM_PORTS  per-master request accepted.
- m_rdata  out  DW*NUM_PORTS  per-master read data.
- m_resp  out  2*NUM_PORTS  per-master response code.
- s_req  out  1  downstream request.
- s_cmd  out  1  downstream command.
- s_width  out  2  downstream width.
- s_addr  out  AW  downstream address.
- s_wdata  out  DW  downstream write data.
- s_req_ack  in  1  downstream accepted request.
- s_rdata  in  DW  downstream read data.
- s_resp  in  2  downstream response (NOTRDY / RDY_OK / RDY_ER).
- resp_unexp  out  1  sticky flag: response arrived with nothing outstanding.

Function
REQ-006 SHALL arbitrate with a two-state FSM, IDLE and LOCKED, plus a registered grant index.
REQ-007 In IDLE, SHALL select round-robin: the first asserted m_req at index above the last accepted port, wrapping; after reset, port 0 has highest priority.
REQ-008 SHALL enter LOCKED on the cycle a grant is issued and hold that grant until s_req & s_req_ack, then return to IDLE; grant never changes while LOCKED.
REQ-009 SHALL forward granted master's cmd/width/addr/wdata to s_* combinationally; s_* data outputs 0 when no grant.
REQ-010 s_req SHALL equal m_req[grant] & ~fifo_full, combinational in grant.
REQ-011 m_req_ack[grant] SHALL equal s_req & s_req_ack; all other m_req_ack bits 0.
REQ-012 On each accepted request SHALL push the grant index into an in-order tag FIFO of OUTST_DEPTH entries.
REQ-013 When s_resp != NOTRDY and FIFO non-empty, SHALL route s_resp and s_rdata to the port at FIFO head in the same cycle (zero latency) and pop the FIFO.
REQ-014 Non-addressed ports SHALL see m_resp = NOTRDY and m_rdata = 0.
REQ-015 FIFO full: s_req held 0, no m_req_ack, even if a pop occurs in the same cycle; arbitration resumes the next cycle.
REQ-016 Simultaneous push and pop with FIFO not full SHALL leave occupancy unchanged.
REQ-017 Response with FIFO empty SHALL be dropped (no m_resp asserted) and SHALL set resp_unexp until reset.
REQ-018 A master dropping m_req while LOCKED and unaccepted SHALL return the FSM to IDLE next cycle with no push.

Reset
REQ-019 On rst: FSM IDLE, grant cleared, round-robin pointer so port 0 wins next, FIFO empty, resp_unexp 0.
REQ-020 During rst all m_req_ack 0, m_resp NOTRDY, s_req 0; reset mid-transaction discards outstanding tags.

Structure
REQ-021 Response encoding and width enum SHALL come from the shared ycr_memif package/header; no local redefinition.
REQ-022 Tag FIFO SHALL be sub-module ycr_tag_fifo (parameters DEPTH, TW=$clog2(NUM_PORTS)), with full/empty/push/pop.

Verification
REQ-023 Ports 0 and 1 request continuously, s_req_ack=1, s_resp RDY_OK one cycle later -> grants alternate 0,1,0,1; each m_resp routed to issuer.
REQ-024 NUM_PORTS=4, all requesting, 1 accepted per cycle -> grant order 0,1,2,3,0.
REQ-025 Port 1 holds request, s_req_ack=0 for 5 cycles while port 0 requests -> grant stays 1; port 0 granted after ack.
REQ-026 OUTST_DEPTH=4, 4 accepts, no responses -> 5th request sees s_req=0; one RDY_OK -> s_req reasserts next cycle.
REQ-027 s_resp=RDY_ER with FIFO empty -> no m_resp, resp_unexp=1 until rst.
REQ-028 rst asserted with 3 outstanding -> FIFO empty next cycle; subsequent s_resp sets resp_unexp.
